sound_write_sequencer: RTL and testbench



---
 rtl/sound_write_pkg.sv | 23 ++
 rtl/sound_byte_fifo.sv | 64 ++++++
 rtl/sound_write_sequencer.sv | 174 +++++++++++++++++
 tb/tb_sound_write_sequencer.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/sound_write_pkg.sv
// Shared definitions for the sound write sequencer: FSM states, default
// tick constants, READY timeout length and a tick-counter load helper.
package sound_write_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } seq_state_t;

    localparam int DEF_FIFO_DEPTH      = 4;
    localparam int DEF_SETUP_TICKS     = 1;
    localparam int DEF_PULSE_TICKS     = 2;
    localparam int DEF_HOLD_TICKS      = 1;
    localparam int READY_TIMEOUT_TICKS = 256;

    // A phase lasting N ticks is counted down from N-1 to 0.
    function automatic logic [7:0] tick_load(input int ticks);
        return 8'(ticks - 1);
    endfunction

endpackage

// File: rtl/sound_byte_fifo.sv
// Small synchronous byte FIFO. Pushes while full and pops while empty are
// ignored; pointers wrap naturally because DEPTH is a power of two.
module sound_byte_fifo
    import sound_write_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    output logic [7:0]    head,
    output logic          full,
    output logic [CW-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign full      = (count_r == CW'(DEPTH));
    assign count     = count_r;
    assign head      = mem_r[rd_ptr_r];
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && (count_r != {CW{1'b0}});

    // Storage array and write pointer advance on accepted pushes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
            wr_ptr_r <= {AW{1'b0}};
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
            wr_ptr_r        <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
        end
    end

    // Read pointer and occupancy; a simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/sound_write_sequencer.sv
// Buffers CPU byte writes and replays each onto DATA with a timed active-low
// nWE pulse. Optional READY handshake with timeout: define SOUND_READY_EN.
module sound_write_sequencer
    import sound_write_pkg::*;
#(
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int SETUP_TICKS = DEF_SETUP_TICKS,
    parameter int PULSE_TICKS = DEF_PULSE_TICKS,
    parameter int HOLD_TICKS  = DEF_HOLD_TICKS
) (
    input  logic       CLK,
    input  logic       nRESET,
    input  logic       CLK_en,
    input  logic       WR_STB,
    input  logic [7:0] WR_DATA,
`ifdef SOUND_READY_EN
    input  logic       READY,
    output logic       READY_TIMEOUT,
`endif
    output logic       FULL,
    output logic       BUSY,
    output logic       OVERFLOW,
    output logic [7:0] DATA,
    output logic       nWE
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    seq_state_t    state_r;
    logic [7:0]    cnt_r;
    logic [7:0]    data_r;
    logic          nwe_r;
    logic          ovf_r;
    logic [7:0]    fifo_head_s;
    logic          fifo_full_s;
    logic [CW-1:0] fifo_count_s;
    logic          fifo_empty_s;
    logic          pop_s;
    logic          strobe_exit_s;

    assign fifo_empty_s = (fifo_count_s == {CW{1'b0}});
    assign pop_s        = CLK_en && (state_r == ST_IDLE) && !fifo_empty_s;
    assign FULL         = fifo_full_s;
    assign BUSY         = !fifo_empty_s || (state_r != ST_IDLE);
    assign OVERFLOW     = ovf_r;
    assign DATA         = data_r;
    assign nWE          = nwe_r;

    sound_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk       (CLK),
        .rst_n     (nRESET),
        .push      (WR_STB),
        .push_data (WR_DATA),
        .pop       (pop_s),
        .head      (fifo_head_s),
        .full      (fifo_full_s),
        .count     (fifo_count_s)
    );

    // Dropped pushes latch the overflow flag until reset.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            ovf_r <= 1'b0;
        end else if (WR_STB && fifo_full_s) begin
            ovf_r <= 1'b1;
        end
    end

`ifdef SOUND_READY_EN
    logic [7:0] wait_cnt_r;
    logic       rto_r;
    logic       timeout_hit_s;

    assign READY_TIMEOUT = rto_r;
    assign timeout_hit_s = !READY && (wait_cnt_r == 8'(READY_TIMEOUT_TICKS - 1));

    // Strobe may only end once the chip is ready, or once READY has been stuck low too long.
    always_comb begin
        strobe_exit_s = 1'b0;
        if (cnt_r == 8'h00) begin
            strobe_exit_s = READY || rto_r || timeout_hit_s;
        end else begin
            strobe_exit_s = 1'b0;
        end
    end

    // Count consecutive READY-low ticks inside STROBE; latch the timeout flag.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            wait_cnt_r <= 8'h00;
            rto_r      <= 1'b0;
        end else if (CLK_en) begin
            if ((state_r != ST_STROBE) || READY) begin
                wait_cnt_r <= 8'h00;
            end else if (timeout_hit_s) begin
                wait_cnt_r <= 8'h00;
                rto_r      <= 1'b1;
            end else begin
                wait_cnt_r <= wait_cnt_r + 8'h01;
            end
        end
    end
`else
    // Without the handshake the strobe ends purely on its tick count.
    always_comb begin
        strobe_exit_s = 1'b0;
        if (cnt_r == 8'h00) begin
            strobe_exit_s = 1'b1;
        end else begin
            strobe_exit_s = 1'b0;
        end
    end
`endif

    // Write sequencer: pop a byte, hold setup, pulse nWE low, hold data, repeat.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_r <= ST_IDLE;
            cnt_r   <= 8'h00;
            data_r  <= 8'h00;
            nwe_r   <= 1'b1;
        end else if (CLK_en) begin
            case (state_r)
                ST_IDLE: begin
                    nwe_r <= 1'b1;
                    if (!fifo_empty_s) begin
                        data_r  <= fifo_head_s;
                        cnt_r   <= tick_load(SETUP_TICKS);
                        state_r <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt_r == 8'h00) begin
                        cnt_r   <= tick_load(PULSE_TICKS);
                        nwe_r   <= 1'b0;
                        state_r <= ST_STROBE;
                    end else begin
                        cnt_r   <= cnt_r - 8'h01;
                        nwe_r   <= 1'b1;
                    end
                end
                ST_STROBE: begin
                    if (strobe_exit_s) begin
                        cnt_r   <= tick_load(HOLD_TICKS);
                        nwe_r   <= 1'b1;
                        state_r <= ST_HOLD;
                    end else if (cnt_r != 8'h00) begin
                        cnt_r   <= cnt_r - 8'h01;
                        nwe_r   <= 1'b0;
                    end else begin
                        nwe_r   <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    nwe_r <= 1'b1;
                    if (cnt_r == 8'h00) begin
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r   <= cnt_r - 8'h01;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= 8'h00;
                    nwe_r   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sound_write_sequencer.sv
// Self-checking bench for sound_write_sequencer (default build, no READY).
// A transaction-level model tracks the queue, the per-byte busy window and
// the expected bus state, and is compared with the DUT every clock.
module tb_sound_write_sequencer;

    localparam int DEPTH = 4;
    localparam int S     = 1;
    localparam int P     = 2;
    localparam int H     = 1;

    logic       CLK = 1'b0;
    logic       nRESET;
    logic       CLK_en;
    logic       WR_STB;
    logic [7:0] WR_DATA;
    logic       FULL;
    logic       BUSY;
    logic       OVERFLOW;
    logic [7:0] DATA;
    logic       nWE;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] mq[$];
    int         m_rem;
    logic [7:0] m_data;
    bit         m_ovf;

    sound_write_sequencer #(
        .FIFO_DEPTH  (DEPTH),
        .SETUP_TICKS (S),
        .PULSE_TICKS (P),
        .HOLD_TICKS  (H)
    ) dut (
        .CLK      (CLK),
        .nRESET   (nRESET),
        .CLK_en   (CLK_en),
        .WR_STB   (WR_STB),
        .WR_DATA  (WR_DATA),
        .FULL     (FULL),
        .BUSY     (BUSY),
        .OVERFLOW (OVERFLOW),
        .DATA     (DATA),
        .nWE      (nWE)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Each byte occupies S+P+H ticks after its pop tick; nWE is low for the P
    // ticks that follow the setup phase.
    function automatic logic exp_nwe();
        return !((m_rem > H) && (m_rem <= H + P));
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_rem  = 0;
        m_data = 8'h00;
        m_ovf  = 1'b0;
    endfunction

    task automatic check_all();
        check_eq("nWE", {31'd0, nWE}, {31'd0, exp_nwe()});
        check_eq("DATA", {24'd0, DATA}, {24'd0, m_data});
        check_eq("FULL", {31'd0, FULL}, {31'd0, (mq.size() == DEPTH)});
        check_eq("BUSY", {31'd0, BUSY}, {31'd0, (mq.size() != 0) || (m_rem != 0)});
        check_eq("OVERFLOW", {31'd0, OVERFLOW}, {31'd0, m_ovf});
    endtask

    // Called at a negedge: check, drive, advance one clock, update model.
    task automatic step(input bit stb, input logic [7:0] d, input bit en);
        bit do_pop;
        bit do_push;
        check_all();
        WR_STB  = stb;
        WR_DATA = d;
        CLK_en  = en;
        @(posedge CLK);
        do_pop  = en && (m_rem == 0) && (mq.size() > 0);
        do_push = stb && (mq.size() < DEPTH);
        if (stb && !do_push) m_ovf = 1'b1;
        if (en && m_rem > 0) m_rem--;
        if (do_pop) begin
            m_data = mq.pop_front();
            m_rem  = S + P + H;
        end
        if (do_push) mq.push_back(d);
        @(negedge CLK);
    endtask

    initial begin
        logic [7:0] six [6];
        int guard;
        six[0] = 8'h80; six[1] = 8'h04; six[2] = 8'hA0;
        six[3] = 8'h02; six[4] = 8'hC0; six[5] = 8'h01;

        nRESET = 1'b0; CLK_en = 1'b0; WR_STB = 1'b0; WR_DATA = 8'h00;
        model_reset();
        repeat (3) @(negedge CLK);
        check_all();                                   // reset values
        nRESET = 1'b1;

        // Single push of 0x80 with CLK_en every clock
        step(1'b1, 8'h80, 1'b1);
        for (int i = 0; i < 12; i++) step(1'b0, 8'h00, 1'b1);

        // Six back-to-back pushes, CLK_en every third clock
        for (int i = 0; i < 6; i++) step(1'b1, six[i], (i % 3) == 0);
        for (int i = 0; i < 90; i++) step(1'b0, 8'h00, (i % 3) == 0);

        // Push 0xE4 on the same clock as the pop of a single queued byte
        step(1'b1, 8'h33, 1'b0);
        step(1'b1, 8'hE4, 1'b1);
        for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b1);

        // Sound_Generator volume traffic
        step(1'b1, 8'h90, 1'b1);
        step(1'b1, 8'hBF, 1'b1);
        step(1'b1, 8'hDF, 1'b1);
        step(1'b1, 8'hF0, 1'b1);
        for (int i = 0; i < 25; i++) step(1'b0, 8'h00, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 2500; i++) begin
            step(($urandom_range(0, 3) == 0), 8'($urandom), ($urandom_range(0, 2) == 0));
        end

        // Reset in the middle of a strobe (OVERFLOW is set by now if any drop happened)
        for (int i = 0; i < 6; i++) step(1'b1, 8'($urandom), 1'b0);
        guard = 0;
        while (exp_nwe() && guard < 50) begin
            step(1'b0, 8'h00, 1'b1);
            guard++;
        end
        check_eq("wait_strobe", {31'd0, exp_nwe()}, 32'd0);
        check_eq("nWE_before_reset", {31'd0, nWE}, 32'd0);
        #2 nRESET = 1'b0;
        #1;
        check_eq("nWE_async_reset", {31'd0, nWE}, 32'd1);
        check_eq("OVERFLOW_async_reset", {31'd0, OVERFLOW}, 32'd0);
        check_eq("BUSY_async_reset", {31'd0, BUSY}, 32'd0);
        check_eq("FULL_async_reset", {31'd0, FULL}, 32'd0);
        model_reset();
        @(negedge CLK);
        nRESET = 1'b1;
        for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b1);
        check_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
